// File: rtl/grayscale_wr_arbiter.sv
// CCI-P c1 write-channel arbiter for the grayscale AFU: data writes (req0) and a
// fenced status write (req1) share one registered request port under an outstanding cap.
package ccip_if_pkg;
  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [511:0] t_ccip_clData;
  typedef logic [15:0]  t_ccip_mdata;

  typedef enum logic [1:0] {
    eVC_VA  = 2'b00,
    eVC_VL0 = 2'b01,
    eVC_VH0 = 2'b10,
    eVC_VH1 = 2'b11
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h1,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h6
  } t_ccip_c1_rsp;

  typedef struct packed {
    logic [5:0]   rsvd2;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;
endpackage

module grayscale_wr_arbiter
  import ccip_if_pkg::*;
#(
  parameter  int unsigned MAX_OUTSTANDING = 64,
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               req0_valid,
  input  t_ccip_c1_ReqMemHdr req0_hdr,
  input  logic [511:0]       req0_data,
  output logic               req0_ack,
  input  logic               req1_valid,
  input  t_ccip_c1_ReqMemHdr req1_hdr,
  input  logic [511:0]       req1_data,
  output logic               req1_ack,
  input  t_if_ccip_Rx        ccip_rx,
  output t_if_ccip_c1_Tx     ccip_c1_tx,
  output logic [CNT_W-1:0]   outstanding,
  output logic               idle,
  output logic               err_underflow
);

  typedef enum logic [1:0] {
    S_ARB_RUN    = 2'd0,
    S_ARB_FENCE  = 2'd1,
    S_ARB_STATUS = 2'd2
  } t_arb_state;

  t_arb_state       r_state;
  t_if_ccip_c1_Tx   r_tx;
  logic [CNT_W-1:0] r_outstanding;
  logic             r_err;

  logic [CNT_W:0]   w_inflight;
  logic             w_can_issue;
  logic             w_drained;
  logic             w_rsp_wr;
  logic             w_unused_rx;

  // The registered request is counted as in flight before it reaches the counter.
  assign w_inflight  = {1'b0, r_outstanding} + {{CNT_W{1'b0}}, r_tx.valid};
  assign w_can_issue = enable && !ccip_rx.c1TxAlmFull
                       && (w_inflight < (CNT_W + 1)'(MAX_OUTSTANDING));
  assign w_drained   = (r_outstanding == '0) && !r_tx.valid;
  assign w_rsp_wr    = ccip_rx.c1.rspValid && (ccip_rx.c1.hdr.resp_type == eRSP_WRLINE);
  assign w_unused_rx = ^ccip_rx;

  always_comb begin
    req0_ack = 1'b0;
    req1_ack = 1'b0;
    if (!reset) begin
      case (r_state)
        S_ARB_RUN:   req0_ack = req0_valid && !req1_valid && w_can_issue;
        S_ARB_FENCE: req1_ack = req1_valid && w_drained && w_can_issue;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_ARB_RUN;
      r_tx          <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      r_tx.valid <= req0_ack || req1_ack;
      if (req1_ack) begin
        r_tx.hdr  <= req1_hdr;
        r_tx.data <= req1_data;
      end else if (req0_ack) begin
        r_tx.hdr  <= req0_hdr;
        r_tx.data <= req0_data;
      end

      if (r_tx.valid && !w_rsp_wr) begin
        if (r_outstanding != '1) r_outstanding <= r_outstanding + CNT_W'(1);
      end else if (!r_tx.valid && w_rsp_wr) begin
        if (r_outstanding == '0) r_err <= 1'b1;
        else                     r_outstanding <= r_outstanding - CNT_W'(1);
      end

      // STATUS also waits for the registered status request itself to leave, so the
      // exit means the status write has been issued and acknowledged.
      case (r_state)
        S_ARB_RUN:    if (req1_valid) r_state <= S_ARB_FENCE;
        S_ARB_FENCE:  if (req1_ack)   r_state <= S_ARB_STATUS;
        S_ARB_STATUS: if (w_drained)  r_state <= S_ARB_RUN;
        default:                      r_state <= S_ARB_RUN;
      endcase
    end
  end

  assign ccip_c1_tx    = r_tx;
  assign outstanding   = r_outstanding;
  assign idle          = (r_state == S_ARB_RUN) && w_drained;
  assign err_underflow = r_err;

  a_req0_held: assert property (@(posedge clk) disable iff (reset)
    (req0_valid && !req0_ack) |=> req0_valid)
    else $error("req0_valid dropped before req0_ack");

  a_req1_held: assert property (@(posedge clk) disable iff (reset)
    (req1_valid && !req1_ack) |=> req1_valid)
    else $error("req1_valid dropped before req1_ack");

endmodule

// File: tb/tb_grayscale_wr_arbiter.sv
// Directed bench for grayscale_wr_arbiter: per-cycle comparison against a
// transaction-level model plus hand-computed checks for each scenario.
`timescale 1ns/1ps
module tb_grayscale_wr_arbiter;
  import ccip_if_pkg::*;

  localparam int MAXO    = 6;
  localparam int CW      = $clog2(MAXO + 1);
  localparam int RSP_DLY = 5;
  localparam logic [41:0] DBASE = 42'h100;
  localparam logic [41:0] SADDR = 42'h3FF00;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic               req0_valid = 1'b0;
  t_ccip_c1_ReqMemHdr req0_hdr = '0;
  logic [511:0]       req0_data = '0;
  logic               req0_ack;
  logic               req1_valid = 1'b0;
  t_ccip_c1_ReqMemHdr req1_hdr = '0;
  logic [511:0]       req1_data = '0;
  logic               req1_ack;
  t_if_ccip_Rx        ccip_rx = '0;
  t_if_ccip_c1_Tx     ccip_c1_tx;
  logic [CW-1:0]      outstanding;
  logic               idle;
  logic               err_underflow;

  always #5 clk = ~clk;

  grayscale_wr_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req0_valid(req0_valid), .req0_hdr(req0_hdr), .req0_data(req0_data), .req0_ack(req0_ack),
    .req1_valid(req1_valid), .req1_hdr(req1_hdr), .req1_data(req1_data), .req1_ack(req1_ack),
    .ccip_rx(ccip_rx), .ccip_c1_tx(ccip_c1_tx), .outstanding(outstanding),
    .idle(idle), .err_underflow(err_underflow)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic t_ccip_c1_ReqMemHdr mkhdr(input logic [41:0] a, input logic [15:0] md);
    t_ccip_c1_ReqMemHdr h;
    h          = '0;
    h.vc_sel   = eVC_VL0;
    h.sop      = 1'b1;
    h.cl_len   = eCL_LEN_1;
    h.req_type = eREQ_WRLINE_I;
    h.address  = a;
    h.mdata    = md;
    return h;
  endfunction

  function automatic logic [511:0] mkdata(input int idx, input logic [31:0] tag);
    logic [31:0] w;
    w = tag ^ 32'(idx);
    return {16{w}};
  endfunction

  // Requester / responder state
  int  r0_idx = 0;
  int  r0_left = 0;
  bit  a0_seen = 0, a1_seen = 0;
  int  rsp_q[$];
  bit  auto_rsp = 0;
  int  cyc = 0;

  // Monitor snapshots and counters
  int  n_a0 = 0, n_a1 = 0, n_tx = 0, peak = 0;
  int  a0_cyc = 0, a1_cyc = 0, rsp_cyc = 0;
  int  mon_out = 0;
  bit  mon_txv = 0, mon_idle = 0, mon_err = 0, mon_dzero = 0, st_seen = 0;
  logic [41:0] mon_addr = '0, first_addr = '0, last_addr = '0;

  // Model: mode 0 = data flowing, 1 = status pending behind data, 2 = status in flight
  int  m_mode = 0;
  int  m_out = 0;
  bit  m_txv = 0, m_err = 0;
  t_ccip_c1_ReqMemHdr m_hdr = '0;
  logic [511:0] m_data = '0;

  task automatic drive_req0();
    req0_valid = (r0_left > 0);
    req0_hdr   = mkhdr(DBASE + 42'(r0_idx), 16'(r0_idx));
    req0_data  = mkdata(r0_idx, 32'hA5A5_0000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (a0_seen && r0_left > 0) begin
      r0_idx++;
      r0_left--;
    end
    if (a1_seen) req1_valid = 1'b0;
    drive_req0();
    ccip_rx.c1.rspValid      = 1'b0;
    ccip_rx.c1.hdr.resp_type = eRSP_WRLINE;
    if (rsp_q.size() > 0 && rsp_q[0] <= cyc) begin
      void'(rsp_q.pop_front());
      ccip_rx.c1.rspValid = 1'b1;
    end
  endtask

  task automatic do_reset();
    tick();
    reset      = 1'b1;
    r0_left    = 0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    auto_rsp   = 0;
    rsp_q.delete();
    tick();
    reset = 1'b0;
  endtask

  task automatic clr_cnt();
    n_a0 = 0; n_a1 = 0; n_tx = 0; peak = 0; st_seen = 0;
  endtask

  initial forever begin
    bit e_can, e_a0, e_a1, e_idle, rsp;
    int n;
    @(negedge clk);
    e_can  = enable && !ccip_rx.c1TxAlmFull && ((m_out + (m_txv ? 1 : 0)) < MAXO);
    e_a0   = !reset && m_mode == 0 && !req1_valid && req0_valid && e_can;
    e_a1   = !reset && m_mode == 1 && req1_valid && m_out == 0 && !m_txv && e_can;
    e_idle = (m_mode == 0) && (m_out == 0) && !m_txv;
    chk("req0_ack", 128'(req0_ack), 128'(e_a0));
    chk("req1_ack", 128'(req1_ack), 128'(e_a1));
    chk("tx_valid", 128'(ccip_c1_tx.valid), 128'(m_txv));
    chk("tx_hdr", 128'(ccip_c1_tx.hdr), 128'(m_hdr));
    chk("tx_data_lo", ccip_c1_tx.data[127:0], m_data[127:0]);
    chk("tx_data_all", 128'(ccip_c1_tx.data == m_data), 128'(1));
    chk("outstanding", 128'(outstanding), 128'(m_out));
    chk("idle", 128'(idle), 128'(e_idle));
    chk("err_underflow", 128'(err_underflow), 128'(m_err));

    a0_seen   = req0_ack;
    a1_seen   = req1_ack;
    mon_out   = int'(outstanding);
    mon_txv   = ccip_c1_tx.valid;
    mon_idle  = idle;
    mon_err   = err_underflow;
    mon_addr  = ccip_c1_tx.hdr.address;
    mon_dzero = (ccip_c1_tx.data == '0);
    if (req0_ack) begin n_a0++; a0_cyc = cyc; end
    if (req1_ack) begin n_a1++; a1_cyc = cyc; end
    if ((req0_ack || req1_ack) && auto_rsp) rsp_q.push_back(cyc + RSP_DLY);
    if (ccip_c1_tx.valid) begin
      if (n_tx == 0) first_addr = ccip_c1_tx.hdr.address;
      last_addr = ccip_c1_tx.hdr.address;
      if (ccip_c1_tx.hdr.address == SADDR) st_seen = 1;
      n_tx++;
    end
    if (ccip_rx.c1.rspValid && ccip_rx.c1.hdr.resp_type == eRSP_WRLINE) rsp_cyc = cyc;
    if (int'(outstanding) > peak) peak = int'(outstanding);

    if (reset) begin
      m_mode = 0; m_out = 0; m_txv = 0; m_err = 0; m_hdr = '0; m_data = '0;
    end else begin
      rsp = ccip_rx.c1.rspValid && (ccip_rx.c1.hdr.resp_type == eRSP_WRLINE);
      n   = m_out + (m_txv ? 1 : 0) - (rsp ? 1 : 0);
      if (n < 0) begin
        n     = 0;
        m_err = 1;
      end
      if (m_mode == 0 && req1_valid)                   m_mode = 1;
      else if (m_mode == 1 && e_a1)                    m_mode = 2;
      else if (m_mode == 2 && m_out == 0 && !m_txv)    m_mode = 0;
      m_txv = e_a0 || e_a1;
      if (e_a1) begin
        m_hdr = req1_hdr; m_data = req1_data;
      end else if (e_a0) begin
        m_hdr = req0_hdr; m_data = req0_data;
      end
      m_out = n;
    end
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    tick();
    tick();
    chk("rst_outstanding", 128'(mon_out), 128'(0));
    chk("rst_idle", 128'(mon_idle), 128'(1));
    chk("rst_txv", 128'(mon_txv), 128'(0));
    chk("rst_err", 128'(mon_err), 128'(0));

    // T1: eight back-to-back data writes, responses 4 cycles after each issue
    enable = 1'b1; auto_rsp = 1; clr_cnt();
    r0_idx = 0; r0_left = 8; drive_req0();
    for (int i = 0; i < 60 && !(r0_left == 0 && rsp_q.size() == 0 && mon_out == 0 && !mon_txv); i++)
      tick();
    tick();
    chk("t1_acks", 128'(n_a0), 128'(8));
    chk("t1_tx", 128'(n_tx), 128'(8));
    chk("t1_peak", 128'(peak), 128'(4));
    chk("t1_end_out", 128'(mon_out), 128'(0));
    chk("t1_first_addr", 128'(first_addr), 128'(DBASE));
    chk("t1_last_addr", 128'(last_addr), 128'(DBASE + 42'd7));

    // T2: cap reached with no responses, one response frees exactly one slot
    do_reset();
    enable = 1'b1; clr_cnt();
    r0_idx = 0; r0_left = 50; drive_req0();
    repeat (12) tick();
    chk("t2_acks", 128'(n_a0), 128'(MAXO));
    chk("t2_out", 128'(mon_out), 128'(MAXO));
    n_a0 = 0;
    ccip_rx.c1.rspValid = 1'b1;
    tick();
    chk("t2_no_early", 128'(n_a0), 128'(0));
    tick();
    chk("t2_one_more", 128'(n_a0), 128'(1));
    repeat (5) tick();
    chk("t2_still_one", 128'(n_a0), 128'(1));

    // T3: almost-full stalls the stream, resumes on the cycle it drops
    do_reset();
    enable = 1'b1; auto_rsp = 1; clr_cnt();
    r0_idx = 0; r0_left = 30; drive_req0();
    repeat (5) tick();
    ccip_rx.c1TxAlmFull = 1'b1; clr_cnt();
    repeat (10) tick();
    chk("t3_acks", 128'(n_a0), 128'(0));
    chk("t3_tx", 128'(n_tx), 128'(1));
    ccip_rx.c1TxAlmFull = 1'b0; n_a0 = 0;
    tick();
    chk("t3_resume", 128'(n_a0), 128'(1));
    for (int i = 0; i < 100 && !(r0_left == 0 && rsp_q.size() == 0 && mon_out == 0 && !mon_txv); i++)
      tick();
    chk("t3_drained", 128'(r0_left == 0 && mon_out == 0), 128'(1));

    // T4: status write fenced behind six outstanding data writes
    do_reset();
    enable = 1'b1; clr_cnt();
    r0_idx = 0; r0_left = 6; drive_req0();
    for (int i = 0; i < 20 && r0_left != 0; i++) tick();
    repeat (3) tick();
    chk("t4_out6", 128'(mon_out), 128'(6));
    r0_left = 3; drive_req0();
    req1_hdr = mkhdr(SADDR, 16'hFFFF); req1_data = mkdata(0, 32'h5757_0000); req1_valid = 1'b1;
    clr_cnt();
    repeat (4) tick();
    chk("t4_no_a0", 128'(n_a0), 128'(0));
    chk("t4_no_a1", 128'(n_a1), 128'(0));
    for (int i = 0; i < 6; i++) begin
      tick();
      ccip_rx.c1.rspValid = 1'b1;
    end
    for (int i = 0; i < 10 && n_a1 == 0; i++) tick();
    chk("t4_a1_gap", 128'(a1_cyc - rsp_cyc), 128'(1));
    chk("t4_no_a0_fence", 128'(n_a0), 128'(0));
    for (int i = 0; i < 5 && !st_seen; i++) tick();
    chk("t4_status_tx", 128'(st_seen), 128'(1));
    ccip_rx.c1.rspValid = 1'b1;
    for (int i = 0; i < 10 && n_a0 == 0; i++) tick();
    chk("t4_run_again", 128'(n_a0), 128'(1));
    chk("t4_a0_after_status", 128'(a0_cyc - rsp_cyc), 128'(2));

    // T5: simultaneous issue and response, ignored fence response, underflow
    do_reset();
    enable = 1'b1; clr_cnt();
    r0_idx = 0; r0_left = 3; drive_req0();
    for (int i = 0; i < 10 && r0_left != 0; i++) tick();
    repeat (3) tick();
    chk("t5_out3", 128'(mon_out), 128'(3));
    r0_left = 1; drive_req0();
    for (int i = 0; i < 5 && r0_left != 0; i++) tick();
    ccip_rx.c1.rspValid = 1'b1;
    repeat (3) tick();
    chk("t5_same_cycle", 128'(mon_out), 128'(3));
    ccip_rx.c1.rspValid = 1'b1;
    ccip_rx.c1.hdr.resp_type = eRSP_WRFENCE;
    tick();
    tick();
    chk("t5_fence_ignored", 128'(mon_out), 128'(3));
    for (int i = 0; i < 3; i++) begin
      ccip_rx.c1.rspValid = 1'b1;
      tick();
    end
    tick();
    chk("t5_out0", 128'(mon_out), 128'(0));
    chk("t5_err_clear", 128'(mon_err), 128'(0));
    ccip_rx.c1.rspValid = 1'b1;
    tick();
    tick();
    chk("t5_err_set", 128'(mon_err), 128'(1));
    chk("t5_out_stays0", 128'(mon_out), 128'(0));

    // T6: reset while fenced with five outstanding
    clr_cnt();
    r0_idx = 0; r0_left = 5; drive_req0();
    for (int i = 0; i < 20 && r0_left != 0; i++) tick();
    repeat (3) tick();
    chk("t6_out5", 128'(mon_out), 128'(5));
    r0_left = 2; drive_req0();
    req1_valid = 1'b1;
    repeat (3) tick();
    chk("t6_fenced_idle_low", 128'(mon_idle), 128'(0));
    reset = 1'b1; r0_left = 0; req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("t6_out", 128'(mon_out), 128'(0));
    chk("t6_txv", 128'(mon_txv), 128'(0));
    chk("t6_idle", 128'(mon_idle), 128'(1));
    chk("t6_err", 128'(mon_err), 128'(0));
    chk("t6_addr", 128'(mon_addr), 128'(0));
    chk("t6_data", 128'(mon_dzero), 128'(1));

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
